// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: bus owner and FSM state encodings.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package mem_arbiter_pkg;

    typedef enum logic {
        OWNER_IFETCH = 1'b0,
        OWNER_DMEM   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam int unsigned STARV_W = 4;
    localparam int unsigned MASK_W  = `DATA_WIDTH / 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle of the memory arbiter: ifetch and dmem client channels plus the shared bus.
interface mem_arbiter_if;

    logic                     ireq_valid;
    logic [`DATA_WIDTH-1:0]   ireq_addr;
    logic                     ireq_ready;
    logic                     irsp_valid;
    logic [`DATA_WIDTH-1:0]   irsp_data;
    logic                     ikill;

    logic                     dreq_valid;
    logic [`DATA_WIDTH-1:0]   dreq_addr;
    logic                     dreq_wen;
    logic [`DATA_WIDTH-1:0]   dreq_wdata;
    logic [`DATA_WIDTH/8-1:0] dreq_wmask;
    logic                     dreq_ready;
    logic                     drsp_valid;
    logic [`DATA_WIDTH-1:0]   drsp_data;

    logic                     bus_req_valid;
    logic                     bus_req_ready;
    logic [`DATA_WIDTH-1:0]   bus_addr;
    logic                     bus_wen;
    logic [`DATA_WIDTH-1:0]   bus_wdata;
    logic [`DATA_WIDTH/8-1:0] bus_wmask;
    logic                     bus_rsp_valid;
    logic [`DATA_WIDTH-1:0]   bus_rsp_data;
    logic                     bus_owner;

    // Arbiter side
    modport slave (
        input  ireq_valid, ireq_addr, ikill,
        input  dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data,
        output ireq_ready, irsp_valid, irsp_data,
        output dreq_ready, drsp_valid, drsp_data,
        output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask, bus_owner
    );

    // Client / bus environment side
    modport master (
        output ireq_valid, ireq_addr, ikill,
        output dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data,
        input  ireq_ready, irsp_valid, irsp_data,
        input  dreq_ready, drsp_valid, drsp_data,
        input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask, bus_owner
    );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection between ifetch and dmem. Fixed dmem priority with ifetch starvation
// override by default; alternating round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               ireq_valid,
    input  logic               dreq_valid,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_e             rr_ptr,
`else
    input  logic [STARV_W-1:0] starv_cnt,
`endif
    output owner_e             winner
);

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [STARV_W-1:0] MAX_WAIT_C = STARV_W'(MAX_WAIT);
`endif

    always_comb begin
        winner = OWNER_IFETCH;
        if (ireq_valid && dreq_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            // rr_ptr holds the side preferred on the next contested grant
            winner = rr_ptr;
`else
            winner = (starv_cnt >= MAX_WAIT_C) ? OWNER_IFETCH : OWNER_DMEM;
`endif
        end else if (dreq_valid) begin
            winner = OWNER_DMEM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter (ifetch read-only, dmem read/write) onto a single bus with one
// transaction outstanding. ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  io
);

    state_e state;
    owner_e owner;
    owner_e winner;
    logic   kill_q;
    logic   any_valid;
    logic   grant;
    logic   ifetch_kill;

    assign any_valid   = io.ireq_valid | io.dreq_valid;
    assign grant       = (state == ST_IDLE) && any_valid && !rst;
    assign ifetch_kill = io.ikill && (owner == OWNER_IFETCH);

    assign io.ireq_ready = grant && (winner == OWNER_IFETCH);
    assign io.dreq_ready = grant && (winner == OWNER_DMEM);
    assign io.bus_owner  = owner;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= OWNER_IFETCH;
        end else if (grant) begin
            rr_ptr <= (winner == OWNER_IFETCH) ? OWNER_DMEM : OWNER_IFETCH;
        end
    end

    mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
        .ireq_valid (io.ireq_valid),
        .dreq_valid (io.dreq_valid),
        .rr_ptr     (rr_ptr),
        .winner     (winner)
    );
`else
    logic [STARV_W-1:0] starv_cnt;

    // Counts consecutive grants lost by a waiting ifetch; saturates rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starv_cnt <= '0;
        end else if (grant) begin
            if (winner == OWNER_IFETCH) begin
                starv_cnt <= '0;
            end else if (io.ireq_valid && (starv_cnt != '1)) begin
                starv_cnt <= starv_cnt + 1'b1;
            end
        end
    end

    mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
        .ireq_valid (io.ireq_valid),
        .dreq_valid (io.dreq_valid),
        .starv_cnt  (starv_cnt),
        .winner     (winner)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            owner            <= OWNER_IFETCH;
            kill_q           <= 1'b0;
            io.bus_req_valid <= 1'b0;
            io.bus_addr      <= '0;
            io.bus_wen       <= 1'b0;
            io.bus_wdata     <= '0;
            io.bus_wmask     <= '0;
            io.irsp_valid    <= 1'b0;
            io.irsp_data     <= '0;
            io.drsp_valid    <= 1'b0;
            io.drsp_data     <= '0;
        end else begin
            io.irsp_valid <= 1'b0;
            io.drsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (any_valid) begin
                        owner            <= winner;
                        io.bus_req_valid <= 1'b1;
                        state            <= ST_REQ;
                        if (winner == OWNER_IFETCH) begin
                            io.bus_addr  <= io.ireq_addr;
                            io.bus_wen   <= 1'b0;
                            io.bus_wdata <= '0;
                            io.bus_wmask <= '0;
                        end else begin
                            io.bus_addr  <= io.dreq_addr;
                            io.bus_wen   <= io.dreq_wen;
                            io.bus_wdata <= io.dreq_wdata;
                            io.bus_wmask <= io.dreq_wmask;
                        end
                    end
                end
                ST_REQ: begin
                    if (ifetch_kill) begin
                        kill_q <= 1'b1;
                    end
                    if (io.bus_req_ready) begin
                        io.bus_req_valid <= 1'b0;
                        state            <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (io.bus_rsp_valid) begin
                        state  <= ST_IDLE;
                        kill_q <= 1'b0;
                        if (owner == OWNER_DMEM) begin
                            io.drsp_valid <= 1'b1;
                            io.drsp_data  <= io.bus_rsp_data;
                        end else if (!(kill_q || io.ikill)) begin
                            // a kill arriving with the response itself still suppresses it
                            io.irsp_valid <= 1'b1;
                            io.irsp_data  <= io.bus_rsp_data;
                        end
                    end else if (ifetch_kill) begin
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
